// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500 sequencer: opcode encoding, core phase
// values and the layout of a program word {operand, opcode}.
package mc14500_pkg;

  localparam logic [3:0] NOPO = 4'h0;
  localparam logic [3:0] LD   = 4'h1;
  localparam logic [3:0] LDC  = 4'h2;
  localparam logic [3:0] AND  = 4'h3;
  localparam logic [3:0] ANDC = 4'h4;
  localparam logic [3:0] OR   = 4'h5;
  localparam logic [3:0] ORC  = 4'h6;
  localparam logic [3:0] XNOR = 4'h7;
  localparam logic [3:0] STO  = 4'h8;
  localparam logic [3:0] STOC = 4'h9;
  localparam logic [3:0] IEN  = 4'hA;
  localparam logic [3:0] OEN  = 4'hB;
  localparam logic [3:0] JMP  = 4'hC;
  localparam logic [3:0] RTN  = 4'hD;
  localparam logic [3:0] SKZ  = 4'hE;
  localparam logic [3:0] NOPF = 4'hF;

  localparam logic STATE_FETCH = 1'b0;
  localparam logic STATE_EXEC  = 1'b1;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 4;
  localparam int OPR_LSB = OPC_LSB + OPC_W;

endpackage

// File: rtl/mc14500_ret_stack.sv
// Circular return-address LIFO: a push onto a full stack overwrites the oldest
// entry, a pop from an empty stack is ignored; both raise sticky flags.
module mc14500_ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_top,
  output logic          o_empty,
  output logic [DW-1:0] o_depth,
  output logic          o_ovf,
  output logic          o_unf
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [PW-1:0] w_top_idx;

  // r_wp is the next free slot; the newest entry sits just below it (mod DEPTH)
  assign w_top_idx = r_wp - 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_depth == '0);
  assign o_depth   = r_depth;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;

  always_ff @(posedge clk_in) begin
    if (rst && i_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_wp    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      r_wp <= r_wp + 1'b1;
      if (r_depth == DW'(DEPTH)) r_ovf <= 1'b1;
      else                       r_depth <= r_depth + 1'b1;
    end else if (i_pop) begin
      if (r_depth == '0) begin
        r_unf <= 1'b1;
      end else begin
        r_wp    <= r_wp - 1'b1;
        r_depth <= r_depth - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// Program sequencer for the MC14500 ICU: PC, ROM address generation, JMP/RTN
// decode with a return stack, and operand-to-I/O address latching.
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         core_state,
  input  logic                         core_skp,
  output logic [ADDR_W-1:0]            prog_addr,
  input  logic [ADDR_W+3:0]            prog_data,
  output logic [3:0]                   core_i,
  output logic [ADDR_W-1:0]            io_addr,
  output logic [$clog2(STACK_DEPTH):0] stk_depth,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VEC);

  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_operand;
  logic              r_skipped;

  logic              w_exec;
  logic              w_jmp;
  logic              w_rtn;
  logic [ADDR_W-1:0] w_top;
  logic              w_empty;
  logic [ADDR_W-1:0] w_rtn_tgt;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_exec    = (core_state == STATE_EXEC);
  assign w_jmp     = w_exec && (r_op == JMP) && !r_skipped;
  assign w_rtn     = w_exec && (r_op == RTN) && !r_skipped;
  assign w_rtn_tgt = w_empty ? RV : w_top;

  assign core_i  = prog_data[OPC_LSB +: OPC_W];
  assign io_addr = r_operand;

  // The EXECUTE-cycle address is both what the ROM fetches and the new PC,
  // which is what removes the bubble after a jump.
  always_comb begin
    w_next_pc = r_pc;
    if (!w_exec)    w_next_pc = r_pc + 1'b1;
    else if (w_jmp) w_next_pc = r_operand;
    else if (w_rtn) w_next_pc = w_rtn_tgt;
  end

  always_comb begin
    prog_addr = r_pc;
    if (!rst)        prog_addr = RV;
    else if (w_exec) prog_addr = w_next_pc;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_pc      <= RV;
      r_op      <= NOPO;
      r_operand <= '0;
      r_skipped <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (!w_exec) begin
        r_op      <= prog_data[OPC_LSB +: OPC_W];
        r_operand <= prog_data[OPR_LSB +: ADDR_W];
        r_skipped <= core_skp;
      end
    end
  end

  mc14500_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_push  (w_jmp),
    .i_pop   (w_rtn),
    .i_data  (r_pc),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_depth (stk_depth),
    .o_ovf   (stk_ovf),
    .o_unf   (stk_unf)
  );

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Bench for mc14500_sequencer: the bench plays ROM and core, and predicts each
// instruction's fetch/execute addresses from an instruction-level model.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  localparam int AW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD) + 1;
  localparam logic [AW-1:0] RESET_VEC = 8'h00;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          core_state = 1'b0;
  logic          core_skp = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [AW+3:0] prog_data;
  logic [3:0]    core_i;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] stk_depth;
  logic          stk_ovf;
  logic          stk_unf;

  mc14500_sequencer #(
    .ADDR_W      (AW),
    .STACK_DEPTH (SD),
    .RESET_VEC   (0)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .core_state (core_state),
    .core_skp   (core_skp),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .core_i     (core_i),
    .io_addr    (io_addr),
    .stk_depth  (stk_depth),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  logic [AW+3:0] rom [256];
  always @(posedge clk_in) prog_data <= rom[prog_addr];

  int checks = 0;
  int failures = 0;

  // instruction-level reference model
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_last_opr;
  logic [AW-1:0] ret_q [$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_skip;
  int            rr_force = -1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (pc=%0h t=%0t)", tag, act, exp, m_pc, $time);
    end
  endtask

  function automatic logic [AW+3:0] wd(input logic [3:0] op, input logic [AW-1:0] opr);
    return {opr, op};
  endfunction

  task automatic fill_rom(input bit with_ctrl);
    for (int i = 0; i < 256; i++) begin
      if (with_ctrl) rom[i] = {AW'($urandom), 4'($urandom_range(0, 15))};
      else           rom[i] = {AW'($urandom), 4'($urandom_range(0, 11))};
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    core_state = 1'b1;
    core_skp = 1'b1;
    #1;
    check("rst_comb_addr", prog_addr, RESET_VEC);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rst_addr", prog_addr, RESET_VEC);
    check("rst_depth", stk_depth, 0);
    check("rst_ovf", stk_ovf, 0);
    check("rst_unf", stk_unf, 0);
    check("rst_io", io_addr, 0);
    @(posedge clk_in); #1;
    rst = 1'b1;
    core_state = STATE_FETCH;
    core_skp = 1'b0;
    m_pc = RESET_VEC;
    m_last_opr = '0;
    ret_q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_skip = 0;
  endtask

  // one full instruction (FETCH + EXECUTE); abort asserts reset in EXECUTE
  task automatic do_instr(input bit abort);
    logic [AW+3:0] w;
    logic [3:0]    op;
    logic [AW-1:0] opr;
    logic [AW-1:0] nxt;
    logic [AW-1:0] exp_a;
    bit            s;
    bit            new_skip;
    bit            rr;
    s   = m_skip;
    w   = rom[m_pc];
    op  = w[3:0];
    opr = w[AW+3:4];
    core_state = STATE_FETCH;
    core_skp = s;
    @(negedge clk_in);
    check("f_addr", prog_addr, m_pc);
    check("f_core_i", core_i, op);
    check("f_io", io_addr, m_last_opr);
    check("f_depth", stk_depth, ret_q.size());
    check("f_ovf", stk_ovf, m_ovf);
    check("f_unf", stk_unf, m_unf);
    @(posedge clk_in); #1;
    m_last_opr = opr;
    if (abort) begin
      do_reset();
      return;
    end
    core_state = STATE_EXEC;
    nxt = m_pc + 8'd1;
    exp_a = nxt;
    new_skip = 0;
    if (!s && op == JMP) begin
      exp_a = opr;
      ret_q.push_back(nxt);
      if (ret_q.size() > SD) begin
        void'(ret_q.pop_front());
        m_ovf = 1;
      end
    end else if (!s && op == RTN) begin
      if (ret_q.size() == 0) begin
        exp_a = RESET_VEC;
        m_unf = 1;
      end else begin
        exp_a = ret_q.pop_back();
      end
      new_skip = 1;
    end else if (!s && op == SKZ) begin
      rr = (rr_force >= 0) ? rr_force[0] : 1'($urandom_range(0, 1));
      new_skip = !rr;
    end
    @(negedge clk_in);
    check("x_addr", prog_addr, exp_a);
    check("x_io", io_addr, opr);
    @(posedge clk_in); #1;
    m_pc = exp_a;
    m_skip = new_skip;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_instr(1'b0);
  endtask

  task automatic load_nest(input logic [AW-1:0] last_word_op);
    fill_rom(0);
    rom[8'h00] = wd(JMP, 8'h10);
    rom[8'h10] = wd(JMP, 8'h20);
    rom[8'h20] = wd(JMP, 8'h30);
    rom[8'h30] = wd(JMP, 8'h40);
    rom[8'h40] = wd(JMP, 8'h50);
    rom[8'h50] = (last_word_op == 0) ? wd(RTN, 8'h00) : wd(JMP, 8'h60);
    rom[8'h42] = wd(RTN, 8'h00);
    rom[8'h32] = wd(RTN, 8'h00);
    rom[8'h22] = wd(RTN, 8'h00);
    rom[8'h12] = wd(RTN, 8'h00);
  endtask

  initial begin
    // linear fetch
    fill_rom(0);
    rom[0] = wd(LD, 8'd5);
    rom[1] = wd(AND, 8'd6);
    rom[2] = wd(OR, 8'd7);
    rom[3] = wd(STO, 8'd8);
    do_reset();
    run(5);

    // jump and call/return with dead slot
    fill_rom(0);
    rom[2] = wd(JMP, 8'h40);
    rom[8'h40] = wd(RTN, 8'h00);
    do_reset();
    run(8);

    // skipped jump after SKZ with RR=0
    fill_rom(0);
    rom[1] = wd(SKZ, 8'h00);
    rom[2] = wd(JMP, 8'h40);
    rr_force = 0;
    do_reset();
    run(5);
    rr_force = -1;

    // five nested calls, five returns (last one underflows)
    load_nest(0);
    do_reset();
    run(18);

    // reset during the EXECUTE of a jump with a full, overflowed stack
    load_nest(1);
    do_reset();
    run(5);
    do_instr(1'b1);
    run(3);

    // PC wrap 0xFF -> 0x00
    fill_rom(0);
    rom[0] = wd(JMP, 8'hFD);
    do_reset();
    run(7);

    // randomized programs
    for (int r = 0; r < 4; r++) begin
      fill_rom(1);
      do_reset();
      run(200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc14500_sequencer.md
Name: mc14500_sequencer

Overview:
- Program sequencer for the MC14500 one-bit ICU core: owns the program counter, a synchronous program ROM port and a return-address stack.
- Decodes JMP and RTN itself, so jumps take effect with no fetch bubble.
- Presents the opcode on the core's I input and the operand field as the I/O address.
- Tracks the core's two-phase FETCH/EXECUTE via the core's state_out and SKP.

Parameters:
ADDR_W, 8, program/IO address width; program word = {operand[ADDR_W-1:0], opcode[3:0]}
STACK_DEPTH, 4, return-stack entries (power of two, >=2)
RESET_VEC, 0, program address fetched first after reset

Ports:
clk_in  in  1  clock, shared with core
rst  in  1  reset, synchronous, active-low
core_state  in  1  core state_out (0=FETCH, 1=DECODE_EXECUTE)
core_skp  in  1  core SKP (current instruction is being skipped)
prog_addr  out  ADDR_W  ROM address; ROM returns data one cycle later
prog_data  in  ADDR_W+4  ROM read data
core_i  out  4  opcode to core I
io_addr  out  ADDR_W  operand address for data_i/data_o selection
stk_depth  out  clog2(STACK_DEPTH)+1  valid stack entries
stk_ovf  out  1  sticky: push onto full stack
stk_unf  out  1  sticky: pop from empty stack

Behaviour:
- Reset (rst=0 at edge):
  - pc<=RESET_VEC; op, operand, skipped cleared; stack emptied (stk_depth=0); stk_ovf=stk_unf=0; io_addr=0.
  - While rst=0, prog_addr=RESET_VEC combinationally, so ROM word RESET_VEC is valid in the first cycle after release. The core is in FETCH in that cycle.
  - Reset mid-instruction discards any pending jump or stack operation.
- core_i = prog_data[3:0], combinational.
- FETCH cycle (core_state=0):
  - prog_addr=pc.
  - At edge: op<=prog_data[3:0], operand<=prog_data[ADDR_W+3:4], io_addr<=prog_data[ADDR_W+3:4], skipped<=core_skp, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0).
- EXECUTE cycle (core_state=1): prog_addr is combinational:
  - op=JMP(4'hC) and !skipped: operand. At edge: push pc (JMP address+1) onto stack; pc<=operand.
  - op=RTN(4'hD) and !skipped: top of stack, or RESET_VEC if empty. At edge: pop; pc<=that address.
  - otherwise: pc; pc unchanged.
- Fetch after JMP: the target word arrives in the following FETCH, so there is zero bubble.
- Fetch after RTN: the core skips that fetch by its own skip logic. The word at JMP+1 is therefore a dead slot, which is the defined call/return idiom.
- Skipped JMP/RTN (skipped=1): no pc change, no stack op. pc still advances in FETCH.
- SKZ: handled by the core; the sequencer only honours skipped.
- Every non-skipped JMP is a call:
  - Push when full: oldest entry is overwritten (circular), stk_depth stays STACK_DEPTH, stk_ovf<=1.
  - Pop when empty: target RESET_VEC, stk_depth stays 0, stk_unf<=1.
  - stk_ovf and stk_unf clear only on reset.
- io_addr holds its value through EXECUTE and the next FETCH until the next FETCH edge. The core's data_i/data_o/write are valid against it.
- Other opcodes (0-B, E, F): no sequencer action.
- Latency: instruction at address A executes two cycles after prog_addr=A.

Decomposition:
- Shared package mc14500_pkg: opcode localparams (NOPO..NOPF, matching core encoding), STATE_FETCH/STATE_EXEC constants, program-word field offsets.
- One sub-module: mc14500_ret_stack (circular LIFO with push/pop/top/depth/ovf/unf). The sequencer instantiates it.

Test Plan:
- Reset/linear:
  - Stimulus: ROM 0..3 = LD/AND/OR/STO with operands 5,6,7,8; release rst.
  - Required: prog_addr 0,0/1,1/2...; core_i=1,3,5,8 in FETCH cycles; io_addr=5,6,7,8 in the matching EXECUTE cycles.
- Jump:
  - Stimulus: ROM[2]=JMP operand 0x40.
  - Required: prog_addr=0x40 in the EXECUTE cycle of the JMP; next core_i=ROM[0x40]; stk_depth=1 holding 3.
- Call/return:
  - Stimulus: JMP 0x40 at 2; RTN at 0x40.
  - Required: prog_addr=3 in the RTN EXECUTE cycle; core skips ROM[3]; ROM[4] executes next; stk_depth=0.
- Skipped JMP:
  - Stimulus: RR=0, SKZ at 1, JMP 0x40 at 2.
  - Required: JMP ignored; prog_addr=3; stack unchanged.
- Overflow/underflow:
  - Stimulus: 5 nested JMPs with STACK_DEPTH=4.
  - Required: stk_ovf=1, depth=4, and 4 RTNs return to the newest 4 addresses.
  - Stimulus: a 5th RTN.
  - Required: prog_addr=RESET_VEC, stk_unf=1.
- PC wrap / reset mid-op:
  - Stimulus: sequential fetch at address 0xFF.
  - Required: next fetch from 0x00.
  - Stimulus: assert rst during the EXECUTE of a JMP.
  - Required: next fetch from RESET_VEC, stack empty, flags 0.
